// File: rtl/gemm_stream_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : gemm_stream_scheduler
// Purpose  : Job-level controller for one fixed-weight GEMM systolic array.
//            Accepts a job descriptor (row count), flushes the array, streams
//            that many activation rows into it under valid/ready flow
//            control, tags each array slot so only real rows are captured at
//            the array output, buffers results in an output FIFO and pulses
//            done when the job completes.
// Ports    : clk, reset (async, active-high)
//            start_valid/start_ready/start_num_rows : job descriptor
//            in_valid/in_ready/in_row               : activation rows in
//            out_valid/out_ready/out_row            : result rows out
//            sa_resetn/sa_activation_inputs         : drive to the array
//            sa_activation_outputs/sa_output_valid  : return from the array
//            busy, done (pulse), err (sticky)       : status
// Revision : 1.0 - initial release
// ============================================================================
module gemm_stream_scheduler #(
  parameter  int SA_SIZE                = 4,
  parameter  int WEIGHT_ACTIVATION_SIZE = 8,
  parameter  int MAX_ROWS               = 16,
  localparam int LATENCY                = 2 * SA_SIZE,
  localparam int FIFO_DEPTH             = LATENCY + 2,
  localparam int CW                     = $clog2(MAX_ROWS + 1),
  localparam int ROW_W                  = SA_SIZE * WEIGHT_ACTIVATION_SIZE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [CW-1:0]    start_num_rows,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [ROW_W-1:0] in_row,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ROW_W-1:0] out_row,
  output logic             sa_resetn,
  output logic [ROW_W-1:0] sa_activation_inputs,
  input  logic [ROW_W-1:0] sa_activation_outputs,
  input  logic             sa_output_valid,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int FCW   = $clog2(FIFO_DEPTH + 1);
  localparam int IFW   = $clog2(LATENCY + 1);
  localparam int SUM_W = $clog2(FIFO_DEPTH + LATENCY + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FLUSH  = 3'd1,
    S_STREAM = 3'd2,
    S_DRAIN  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      num_rows_q, num_rows_d;
  logic [CW-1:0]      issued_q, issued_d;
  logic [LATENCY-1:0] tag_q, tag_d;
  logic               err_q, err_d;
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [FCW-1:0]     count_q, count_d;
  logic [ROW_W-1:0]   fifo_mem_q [FIFO_DEPTH];

  logic               accept;
  logic               capture;
  logic               push;
  logic               pop;
  logic               full;
  logic [IFW-1:0]     inflight;

  function automatic logic [IFW-1:0] popcount(input logic [LATENCY-1:0] v);
    logic [IFW-1:0] n;
    n = '0;
    for (int i = 0; i < LATENCY; i++) begin
      n = n + IFW'(v[i]);
    end
    return n;
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign inflight  = popcount(tag_q);
  assign capture   = tag_q[LATENCY-1];
  assign full      = (count_q == FCW'(FIFO_DEPTH));
  assign out_valid = (count_q != '0);
  assign out_row   = fifo_mem_q[rd_ptr_q];
  assign pop       = out_valid && out_ready;
  // A full FIFO can still take a row when the head leaves in the same cycle.
  assign push      = capture && (!full || pop);

  // Credit check: every row already in the array plus every buffered row
  // must fit in the FIFO, so a capture can never be refused.
  assign in_ready  = (state_q == S_STREAM) && (issued_q < num_rows_q) &&
                     ((SUM_W'(inflight) + SUM_W'(count_q)) < SUM_W'(FIFO_DEPTH));
  assign accept    = in_valid && in_ready;

  // Non-accepted cycles present a zero bubble to the array.
  assign sa_activation_inputs = accept ? in_row : '0;

  assign start_ready = (state_q == S_IDLE) && !reset;
  assign sa_resetn   = (state_q != S_FLUSH);
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign err         = err_q;

  always_comb begin
    state_d    = state_q;
    num_rows_d = num_rows_q;
    issued_d   = issued_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q + FCW'(push) - FCW'(pop);
    err_d      = err_q;

    // The tag pipeline mirrors the array; flushing the array empties it.
    tag_d = (state_q == S_FLUSH) ? '0 : {tag_q[LATENCY-2:0], accept};

    if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);

    if (capture && !sa_output_valid) err_d = 1'b1;
    if (capture && !push)            err_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (start_valid) begin
          num_rows_d = start_num_rows;
          issued_d   = '0;
          state_d    = (start_num_rows == '0) ? S_DONE : S_FLUSH;
        end
      end
      S_FLUSH: begin
        state_d = S_STREAM;
      end
      S_STREAM: begin
        if (accept) issued_d = issued_q + CW'(1);
        if (issued_d == num_rows_q) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        // Looking at next-cycle occupancy lets done follow the last pop
        // directly instead of one cycle later.
        if ((popcount(tag_d) == '0) && (count_d == '0)) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      num_rows_q <= '0;
      issued_q   <= '0;
      tag_q      <= '0;
      err_q      <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      num_rows_q <= num_rows_d;
      issued_q   <= issued_d;
      tag_q      <= tag_d;
      err_q      <= err_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // Storage needs no reset: occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wr_ptr_q] <= sa_activation_outputs;
  end

endmodule
`default_nettype wire

// File: tb/tb_gemm_stream_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_gemm_stream_scheduler
// Purpose  : Self-checking bench for gemm_stream_scheduler with a behavioural
//            fixed-weight array stub and a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_gemm_stream_scheduler;

  localparam int SA  = 4;
  localparam int WA  = 8;
  localparam int MR  = 16;
  localparam int LAT = 2 * SA;
  localparam int FD  = LAT + 2;
  localparam int CW  = $clog2(MR + 1);
  localparam int RW  = SA * WA;

  logic          clk = 1'b0;
  logic          reset;
  logic          start_valid;
  logic          start_ready;
  logic [CW-1:0] start_num_rows;
  logic          in_valid;
  logic          in_ready;
  logic [RW-1:0] in_row;
  logic          out_valid;
  logic          out_ready;
  logic [RW-1:0] out_row;
  logic          sa_resetn;
  logic [RW-1:0] sa_activation_inputs;
  logic [RW-1:0] sa_activation_outputs;
  logic          sa_output_valid;
  logic          busy;
  logic          done;
  logic          err;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  gemm_stream_scheduler #(.SA_SIZE(SA), .WEIGHT_ACTIVATION_SIZE(WA), .MAX_ROWS(MR)) dut (
    .clk(clk), .reset(reset),
    .start_valid(start_valid), .start_ready(start_ready), .start_num_rows(start_num_rows),
    .in_valid(in_valid), .in_ready(in_ready), .in_row(in_row),
    .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
    .sa_resetn(sa_resetn), .sa_activation_inputs(sa_activation_inputs),
    .sa_activation_outputs(sa_activation_outputs), .sa_output_valid(sa_output_valid),
    .busy(busy), .done(done), .err(err)
  );

  // Fixed-weight array: lane i multiplies by (i+2) and adds 0x11.
  function automatic logic [RW-1:0] arr_fn(input logic [RW-1:0] r);
    logic [RW-1:0] o;
    for (int i = 0; i < SA; i++) o[i*WA +: WA] = WA'(r[i*WA +: WA] * (i + 2) + 8'h11);
    return o;
  endfunction

  // Array stub: LAT-cycle delay line, output valid once LAT cycles past flush.
  logic [RW-1:0] pipe [LAT];
  int vcnt = 0;
  always @(posedge clk) begin
    if (!sa_resetn) begin
      for (int i = 0; i < LAT; i++) pipe[i] <= '0;
      vcnt <= 0;
    end else begin
      pipe[0] <= sa_activation_inputs;
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
      if (vcnt < LAT) vcnt <= vcnt + 1;
    end
  end
  assign sa_activation_outputs = arr_fn(pipe[LAT-1]);
  assign sa_output_valid       = (vcnt == LAT);

  // Event log, sampled mid-cycle.
  logic [RW-1:0] acc_row[$];
  logic [RW-1:0] pop_row[$];
  int acc_cyc[$];
  int pop_cyc[$];
  int done_cyc[$];
  int busy_n, flush_n, hs_cyc;

  always @(negedge clk) begin
    if (!reset) begin
      if (start_valid && start_ready) hs_cyc = cyc;
      if (in_valid && in_ready) begin acc_row.push_back(in_row); acc_cyc.push_back(cyc); end
      if (out_valid && out_ready) begin pop_row.push_back(out_row); pop_cyc.push_back(cyc); end
      if (done) done_cyc.push_back(cyc);
      if (busy) busy_n++;
      if (!sa_resetn) flush_n++;
    end
  end

  task automatic clear_log();
    acc_row.delete(); pop_row.delete(); acc_cyc.delete(); pop_cyc.delete(); done_cyc.delete();
    busy_n = 0; flush_n = 0; hs_cyc = -1;
  endtask

  task automatic start_job(input int n);
    @(posedge clk); #1;
    start_valid = 1'b1; start_num_rows = CW'(n);
    @(posedge clk); #1;
    start_valid = 1'b0;
  endtask

  // vmode: 0 always valid, 1 valid every third cycle. rmode: 0 ready, 1 stalled, 2 random.
  task automatic drive(input int max_cyc, input int vmode, input int rmode,
                       input bit stop_on_done, input bit rand_rows, output bit timed_out);
    int prev_acc;
    prev_acc  = acc_row.size();
    timed_out = stop_on_done;
    for (int k = 0; k < max_cyc; k++) begin
      if (rand_rows && acc_row.size() != prev_acc) begin in_row = $urandom; prev_acc = acc_row.size(); end
      in_valid  = (vmode == 0) ? 1'b1 : (k % 3 == 0);
      out_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      if (stop_on_done && done_cyc.size() != 0) begin timed_out = 1'b0; break; end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start_valid = 0; start_num_rows = '0; in_valid = 0; in_row = '0; out_ready = 1;
    #2;
    checks++;
    if ({start_ready, in_ready, out_valid, sa_resetn, busy, done, err} !== 7'b0001000) begin
      failures++;
      $display("FAIL reset_outputs: got %b want 0001000", {start_ready, in_ready, out_valid, sa_resetn, busy, done, err});
    end
    checks++;
    if (sa_activation_inputs !== '0) begin failures++; $display("FAIL reset_sa_in: got %h want 0", sa_activation_inputs); end
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    checks++;
    if (start_ready !== 1'b1) begin failures++; $display("FAIL idle_start_ready: got %b want 1", start_ready); end
  endtask

  task automatic test_single_row();
    bit to;
    clear_log();
    in_row = {8'd4, 8'd3, 8'd2, 8'd1};
    start_job(1);
    drive(60, 0, 0, 1, 0, to);
    checks++; if (to) begin failures++; $display("FAIL single_timeout: got no done want done"); end
    checks++;
    if (acc_cyc.size() != 1 || acc_cyc[0] != hs_cyc + 2) begin
      failures++; $display("FAIL single_accept: got n=%0d c=%0d want n=1 c=%0d", acc_cyc.size(), acc_cyc.size() ? acc_cyc[0] : -1, hs_cyc + 2);
    end
    checks++;
    if (pop_cyc.size() != 1 || acc_cyc.size() != 1) begin
      failures++; $display("FAIL single_pops: got %0d want 1", pop_cyc.size());
    end else begin
      checks++;
      if (pop_cyc[0] - acc_cyc[0] != LAT + 1) begin failures++; $display("FAIL single_latency: got %0d want %0d", pop_cyc[0] - acc_cyc[0], LAT + 1); end
      checks++;
      if (pop_row[0] !== arr_fn(32'h04030201)) begin failures++; $display("FAIL single_data: got %h want %h", pop_row[0], arr_fn(32'h04030201)); end
      checks++;
      if (done_cyc.size() != 1 || done_cyc[0] != pop_cyc[0] + 1) begin
        failures++; $display("FAIL single_done: got n=%0d c=%0d want c=%0d", done_cyc.size(), done_cyc.size() ? done_cyc[0] : -1, pop_cyc[0] + 1);
      end
    end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL single_err: got %b want 0", err); end
  endtask

  task automatic test_back_to_back();
    bit to;
    clear_log();
    in_row = $urandom;
    start_job(16);
    drive(100, 0, 0, 1, 1, to);
    checks++; if (to) begin failures++; $display("FAIL burst_timeout: got no done want done"); end
    checks++;
    if (acc_cyc.size() != 16 || pop_cyc.size() != 16) begin
      failures++; $display("FAIL burst_counts: got acc=%0d pop=%0d want 16/16", acc_cyc.size(), pop_cyc.size());
    end else begin
      for (int i = 0; i < 16; i++) begin
        checks++;
        if (acc_cyc[i] != acc_cyc[0] + i || pop_cyc[i] != acc_cyc[i] + LAT + 1 || pop_row[i] !== arr_fn(acc_row[i])) begin
          failures++;
          $display("FAIL burst_row%0d: got acc=%0d pop=%0d data=%h want acc=%0d pop=%0d data=%h", i, acc_cyc[i], pop_cyc[i],
                   pop_row[i], acc_cyc[0] + i, acc_cyc[i] + LAT + 1, arr_fn(acc_row[i]));
        end
      end
      checks++;
      if (done_cyc.size() != 1 || done_cyc[0] != pop_cyc[15] + 1) begin
        failures++; $display("FAIL burst_done: got n=%0d want 1 at %0d", done_cyc.size(), pop_cyc[15] + 1);
      end
    end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL burst_err: got %b want 0", err); end
  endtask

  task automatic test_backpressure();
    bit to;
    clear_log();
    in_row = $urandom;
    start_job(16);
    drive(30, 0, 1, 0, 1, to);
    checks++;
    if (acc_row.size() != FD || pop_row.size() != 0) begin
      failures++; $display("FAIL bp_credit: got acc=%0d pop=%0d want %0d/0", acc_row.size(), pop_row.size(), FD);
    end
    drive(200, 0, 0, 1, 1, to);
    checks++; if (to) begin failures++; $display("FAIL bp_timeout: got no done want done"); end
    checks++;
    if (acc_row.size() != 16 || pop_row.size() != 16) begin
      failures++; $display("FAIL bp_counts: got acc=%0d pop=%0d want 16/16", acc_row.size(), pop_row.size());
    end else begin
      for (int i = 0; i < 16; i++) begin
        checks++;
        if (pop_row[i] !== arr_fn(acc_row[i])) begin failures++; $display("FAIL bp_row%0d: got %h want %h", i, pop_row[i], arr_fn(acc_row[i])); end
      end
    end
    checks++; if (done_cyc.size() != 1) begin failures++; $display("FAIL bp_done: got %0d want 1", done_cyc.size()); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL bp_err: got %b want 0", err); end
  endtask

  task automatic test_gappy();
    bit to;
    clear_log();
    in_row = $urandom;
    start_job(7);
    drive(300, 1, 2, 1, 1, to);
    checks++; if (to) begin failures++; $display("FAIL gappy_timeout: got no done want done"); end
    checks++;
    if (acc_row.size() != 7 || pop_row.size() != 7) begin
      failures++; $display("FAIL gappy_counts: got acc=%0d pop=%0d want 7/7", acc_row.size(), pop_row.size());
    end else begin
      for (int i = 0; i < 7; i++) begin
        checks++;
        if (pop_row[i] !== arr_fn(acc_row[i])) begin failures++; $display("FAIL gappy_row%0d: got %h want %h", i, pop_row[i], arr_fn(acc_row[i])); end
      end
    end
    checks++; if (done_cyc.size() != 1) begin failures++; $display("FAIL gappy_done: got %0d want 1", done_cyc.size()); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL gappy_err: got %b want 0", err); end
  endtask

  task automatic test_zero_rows();
    bit to;
    clear_log();
    start_job(0);
    drive(10, 0, 0, 1, 1, to);
    checks++;
    if (done_cyc.size() != 1 || done_cyc[0] != hs_cyc + 1) begin
      failures++; $display("FAIL zero_done: got n=%0d c=%0d want c=%0d", done_cyc.size(), done_cyc.size() ? done_cyc[0] : -1, hs_cyc + 1);
    end
    checks++;
    if (busy_n != 1 || flush_n != 0 || acc_row.size() != 0) begin
      failures++; $display("FAIL zero_status: got busy=%0d flush=%0d acc=%0d want 1/0/0", busy_n, flush_n, acc_row.size());
    end
  endtask

  task automatic test_reset_mid_job();
    bit to;
    clear_log();
    in_row = $urandom;
    start_job(8);
    drive(12, 0, 1, 0, 1, to);
    in_valid = 1'b1;
    checks++;
    if (!out_valid || acc_row.size() != 8 || done_cyc.size() != 0) begin
      failures++; $display("FAIL midrst_pre: got ov=%b acc=%0d done=%0d want 1/8/0", out_valid, acc_row.size(), done_cyc.size());
    end
    #1 reset = 1'b1;
    #1;
    checks++;
    if ({out_valid, busy, err, start_ready, in_ready} !== 5'b00000) begin
      failures++; $display("FAIL midrst_async: got %b want 00000", {out_valid, busy, err, start_ready, in_ready});
    end
    in_valid = 1'b0;
    @(posedge clk); #1 reset = 1'b0;
    clear_log();
    in_row = $urandom;
    start_job(3);
    drive(100, 0, 0, 1, 1, to);
    checks++; if (to) begin failures++; $display("FAIL midrst_timeout: got no done want done"); end
    checks++;
    if (acc_row.size() != 3 || pop_row.size() != 3) begin
      failures++; $display("FAIL midrst_counts: got acc=%0d pop=%0d want 3/3", acc_row.size(), pop_row.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (pop_row[i] !== arr_fn(acc_row[i])) begin failures++; $display("FAIL midrst_row%0d: got %h want %h", i, pop_row[i], arr_fn(acc_row[i])); end
      end
    end
    checks++; if (err !== 1'b0 || done_cyc.size() != 1) begin failures++; $display("FAIL midrst_end: got err=%b done=%0d want 0/1", err, done_cyc.size()); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_row();
    test_back_to_back();
    test_backpressure();
    test_gappy();
    test_zero_rows();
    test_reset_mid_job();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/gemm_stream_scheduler.md
# gemm_stream_scheduler

Job-level controller that sequences one `GEMM_Fixed_Weights_Each_Cycle` instance. It accepts a job descriptor giving a row count, then flushes the array and streams that many activation rows into it under valid/ready flow control. It tags every array slot so that only real rows are captured at the array output, buffers results in an output FIFO sized to absorb every in-flight row, and signals job completion. It sits between the host-side row streams and the fixed-weight GEMM datapath.

## Interface
- `SA_SIZE`, 4: array dimension; row width is SA_SIZE lanes.
- `WEIGHT_ACTIVATION_SIZE`, 8: bits per lane.
- `MAX_ROWS`, 16: maximum rows per job.
- Derived `LATENCY` = 2*SA_SIZE: array input-to-output delay, in cycles.
- Derived `FIFO_DEPTH` = LATENCY+2: output FIFO entries.
- Derived `CW` = $clog2(MAX_ROWS+1): row-count width.

Ports:
- `clk` in 1: single clock; all logic on posedge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `start_valid` in 1 / `start_ready` out 1: job descriptor handshake.
- `start_num_rows` in CW: rows in this job, 0..MAX_ROWS.
- `in_valid` in 1 / `in_ready` out 1: activation row handshake.
- `in_row` in SA_SIZE x WEIGHT_ACTIVATION_SIZE: activation row.
- `out_valid` out 1 / `out_ready` in 1: result row handshake.
- `out_row` out SA_SIZE x WEIGHT_ACTIVATION_SIZE: result row, taken from the FIFO head.
- `sa_resetn` out 1: synchronous active-low flush to the array.
- `sa_activation_inputs` out SA_SIZE x WEIGHT_ACTIVATION_SIZE: row driven to the array.
- `sa_activation_outputs` in SA_SIZE x WEIGHT_ACTIVATION_SIZE: row returned by the array.
- `sa_output_valid` in 1: array warm-up indicator.
- `busy` out 1: asserted in any state except IDLE.
- `done` out 1: one-cycle pulse when a job completes.
- `err` out 1: sticky protocol error flag.

## Operation
- FSM states: IDLE, FLUSH, STREAM, DRAIN, DONE.
- IDLE:
  - `start_ready`=1.
  - On a start handshake, latch `start_num_rows` into `num_rows` and clear `issued`.
  - If the latched count is 0, go to DONE. Otherwise go to FLUSH.
- FLUSH:
  - Lasts exactly 1 cycle with `sa_resetn`=0.
  - Clears the tag pipeline, then goes to STREAM.
  - The output FIFO is not cleared.
- STREAM:
  - `in_ready` = (`issued` < `num_rows`) && (`inflight` + `fifo_count` < FIFO_DEPTH).
  - `inflight` is the popcount of the tag pipeline.
  - On accept, increment `issued`.
  - When `issued` reaches `num_rows`, go to DRAIN.
- Array input: `sa_activation_inputs` = `in_row` when `in_valid && in_ready`, otherwise all zeros (a bubble). This path is combinational.
- Tag pipeline:
  - LATENCY-bit shift register; `tag[0]` is loaded with the accept bit each cycle.
  - Capture condition: when `tag[LATENCY-1]`=1, push `sa_activation_outputs` into the FIFO.
  - If `sa_output_valid`=0 at a capture, set `err`. The row is still pushed.
- DRAIN: leave when `inflight`==0 and `fifo_count`==0, then go to DONE.
- DONE: `done`=1 for 1 cycle, then go to IDLE.
- `err` is cleared only by `reset`.
- Output FIFO:
  - Pop on `out_valid && out_ready`.
  - Push and pop in the same cycle are both performed; count is unchanged.
  - The credit rule guarantees a push never meets a full FIFO. If one does, set `err` and drop the row.
- Reset values:
  - `start_ready`=0 while `reset` is asserted, then 1 in IDLE.
  - `in_ready`=0, `out_valid`=0, `sa_resetn`=1, `sa_activation_inputs`=0.
  - `busy`=0, `done`=0, `err`=0.
  - FIFO empty, tags all 0, state IDLE.
- Reset mid-job: `reset` aborts immediately.
  - In-flight rows and FIFO contents are discarded.
  - No `done` pulse is produced.
  - The next job's FLUSH re-initialises the array.

## Timing
- Start handshake at edge E0 → FLUSH during cycle 1 → STREAM from cycle 2. `in_ready` can first be 1 in cycle 2.
- Row accepted in cycle c:
  - Appears on `sa_activation_outputs` in cycle c+LATENCY.
  - Written to the FIFO at the end of that cycle.
  - `out_valid` is 1 in cycle c+LATENCY+1.
  - Minimum in→out latency is LATENCY+1 = 9 cycles at the defaults.
- Back-to-back rows sustain 1 row/cycle while `out_ready`=1.
- `done` is asserted in the cycle after the last FIFO pop, provided no rows remain in flight.
- A new job may start in the cycle after `done` (IDLE).
- `in_ready` does not depend combinationally on `in_valid`. `out_valid` does not depend combinationally on `out_ready`.

## Test plan
- Single row, num_rows=1, `in_row`={1,2,3,4}, `out_ready`=1 → `out_valid` 9 cycles after accept; `out_row` equals the array result; `done` the cycle after the pop; `err`=0.
- Burst, num_rows=16, continuous `in_valid` and `out_ready` → 16 accepts in consecutive cycles; 16 results in order, 1 per cycle; exactly one `done`.
- Backpressure, num_rows=16, `out_ready`=0 → accepts stop at 10 (FIFO_DEPTH); after raising `out_ready`, all 16 rows emerge in order; no `err`.
- Gappy input, `in_valid` toggling 1,0,0,1,... → results carry no bubble rows; exactly num_rows pops occur.
- num_rows=0 → `busy` high 1 cycle; `done` 1 cycle after the start handshake; `sa_resetn` stays 1.
- `reset` asserted with 5 rows in flight and 3 in the FIFO → asynchronously, in the same cycle, `out_valid`=0, `busy`=0 and `err`=0. The next job completes correctly, with no stale rows output.
